// File: rtl/instr_issuer_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | instr_issuer_if : program-load / run-control / issue bus             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface instr_issuer_if #(
    parameter int INSTR_WIDTH    = 20,
    parameter int PROG_ADDR_BITS = 5
);
    logic                      load_en;
    logic [PROG_ADDR_BITS-1:0] load_addr;
    logic [INSTR_WIDTH-1:0]    load_data;
    logic [PROG_ADDR_BITS:0]   prog_len;
    logic                      start;
    logic                      stop;
    logic [INSTR_WIDTH-1:0]    instruction;
    logic                      issue_valid;
    logic                      busy;
    logic                      done;
    logic [PROG_ADDR_BITS-1:0] pc;

    modport master (
        output load_en, load_addr, load_data, prog_len, start, stop,
        input  instruction, issue_valid, busy, done, pc
    );

    modport slave (
        input  load_en, load_addr, load_data, prog_len, start, stop,
        output instruction, issue_valid, busy, done, pc
    );
endinterface
`default_nettype wire

// File: rtl/instr_issuer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | instr_issuer : issues a loaded program, holding each word for a      |
// | class-dependent cycle count. INSTR_ISSUER_LOOP_EN: loop until stop.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module instr_issuer #(
    parameter int INSTR_WIDTH    = 20,
    parameter int PROG_ADDR_BITS = 5,
    parameter int STD_CYCLES     = 3,
    parameter int MEM_CYCLES     = 4
) (
    input  logic           clk,
    input  logic           rst,
    instr_issuer_if.slave  bus
);
    localparam int DEPTH    = 1 << PROG_ADDR_BITS;
    localparam int HOLD_MAX = (STD_CYCLES > MEM_CYCLES) ? STD_CYCLES : MEM_CYCLES;
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    logic [INSTR_WIDTH-1:0]    store_q [DEPTH];
    state_t                    state_q, state_d;
    logic [PROG_ADDR_BITS-1:0] pc_q, pc_d;
    logic [PROG_ADDR_BITS:0]   len_q, len_d;
    logic [HOLD_W-1:0]         hold_q, hold_d;
    logic                      stop_q, stop_d;
    logic [INSTR_WIDTH-1:0]    instr_q, instr_d;
    logic                      valid_q, valid_d;

    logic [PROG_ADDR_BITS-1:0] w_pc_next;
    logic [PROG_ADDR_BITS-1:0] w_pc_adv;
    logic                      w_last;
    logic                      w_stop_now;
    logic                      w_end_run;
    logic [INSTR_WIDTH-1:0]    w_word0;
    logic [INSTR_WIDTH-1:0]    w_adv_word;

    // Hold count is taken from the class field in the top two bits.
    function automatic logic [HOLD_W-1:0] hold_for(input logic [INSTR_WIDTH-1:0] w);
        case (w[INSTR_WIDTH-1 -: 2])
            2'b00:   return HOLD_W'(1);
            2'b01:   return HOLD_W'(STD_CYCLES);
            default: return HOLD_W'(MEM_CYCLES);
        endcase
    endfunction

    assign w_pc_next  = pc_q + 1'b1;
    assign w_last     = ({1'b0, pc_q} == (len_q - 1'b1));
    assign w_stop_now = stop_q | bus.stop;
    assign w_word0    = store_q[{PROG_ADDR_BITS{1'b0}}];

`ifdef INSTR_ISSUER_LOOP_EN
    assign w_end_run = w_stop_now;
    assign w_pc_adv  = w_last ? {PROG_ADDR_BITS{1'b0}} : w_pc_next;
`else
    assign w_end_run = w_stop_now | w_last;
    assign w_pc_adv  = w_pc_next;
`endif

    assign w_adv_word = store_q[w_pc_adv];

    // Store has no reset so a program survives rst.
    always_ff @(posedge clk) begin
        if (state_q == S_IDLE && bus.load_en) begin
            store_q[bus.load_addr] <= bus.load_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            len_q   <= '0;
            hold_q  <= '0;
            stop_q  <= 1'b0;
            instr_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            len_q   <= len_d;
            hold_q  <= hold_d;
            stop_q  <= stop_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        len_d   = len_q;
        hold_d  = hold_q;
        stop_d  = stop_q;
        instr_d = instr_q;
        valid_d = valid_q;
        case (state_q)
            S_IDLE: begin
                instr_d = '0;
                valid_d = 1'b0;
                stop_d  = 1'b0;
                hold_d  = '0;
                if (bus.start) begin
                    len_d = bus.prog_len;
                    pc_d  = '0;
                    if (bus.prog_len != '0) begin
                        state_d = S_ISSUE;
                        instr_d = w_word0;
                        valid_d = 1'b1;
                        hold_d  = hold_for(w_word0);
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_ISSUE: begin
                stop_d = w_stop_now;
                if (hold_q > HOLD_W'(1)) begin
                    hold_d = hold_q - 1'b1;
                end else if (w_end_run) begin
                    state_d = S_DONE;
                    instr_d = '0;
                    valid_d = 1'b0;
                    hold_d  = '0;
                    stop_d  = 1'b0;
                end else begin
                    pc_d    = w_pc_adv;
                    instr_d = w_adv_word;
                    hold_d  = hold_for(w_adv_word);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                instr_d = '0;
                valid_d = 1'b0;
                hold_d  = '0;
                stop_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                instr_d = '0;
                valid_d = 1'b0;
                hold_d  = '0;
                stop_d  = 1'b0;
            end
        endcase
    end

    assign bus.instruction = instr_q;
    assign bus.issue_valid = valid_q;
    assign bus.busy        = (state_q == S_ISSUE);
    assign bus.done        = (state_q == S_DONE);
    assign bus.pc          = pc_q;
endmodule
`default_nettype wire

// File: tb/tb_instr_issuer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_instr_issuer : directed runs checked through an expected queue.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_instr_issuer;
    logic clk;
    logic rst;

    instr_issuer_if #(.INSTR_WIDTH(20), .PROG_ADDR_BITS(5)) bus ();

    instr_issuer #(
        .INSTR_WIDTH(20), .PROG_ADDR_BITS(5), .STD_CYCLES(3), .MEM_CYCLES(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [19:0] instr;
        logic [4:0]  pc;
        logic        is_done;
    } exp_t;

    exp_t exp_q[$];
    int   vectors    = 0;
    int   miscompares = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic exp_word(input logic [19:0] w, input logic [4:0] p, input int n);
        exp_t e;
        e.instr = w; e.pc = p; e.is_done = 1'b0;
        for (int i = 0; i < n; i++) exp_q.push_back(e);
    endtask

    task automatic exp_done();
        exp_t e;
        e.instr = '0; e.pc = '0; e.is_done = 1'b1;
        exp_q.push_back(e);
    endtask

    // Monitor: every presented word or done pulse consumes one expected entry.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (bus.issue_valid || bus.done) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_output: got valid=%0b done=%0b instr=%h pc=%0d, expected nothing",
                             bus.issue_valid, bus.done, bus.instruction, bus.pc);
                end else begin
                    e = exp_q.pop_front();
                    if (e.is_done) begin
                        if ({bus.issue_valid, bus.busy, bus.done, bus.instruction} !== {3'b001, 20'h0}) begin
                            miscompares++;
                            $display("FAIL done_pulse: got valid=%0b busy=%0b done=%0b instr=%h, expected 0 0 1 00000",
                                     bus.issue_valid, bus.busy, bus.done, bus.instruction);
                        end
                    end else if ({bus.issue_valid, bus.busy, bus.done, bus.instruction, bus.pc}
                                 !== {3'b110, e.instr, e.pc}) begin
                        miscompares++;
                        $display("FAIL issue_word: got valid=%0b busy=%0b done=%0b instr=%h pc=%0d, expected 1 1 0 %h pc=%0d",
                                 bus.issue_valid, bus.busy, bus.done, bus.instruction, bus.pc, e.instr, e.pc);
                    end
                end
            end else begin
                vectors++;
                if (bus.instruction !== 20'h0 || bus.busy !== 1'b0) begin
                    miscompares++;
                    $display("FAIL idle_outputs: got instr=%h busy=%0b, expected 00000 0",
                             bus.instruction, bus.busy);
                end
            end
        end
    end

    task automatic load(input logic [4:0] a, input logic [19:0] d);
        bus.load_en = 1'b1; bus.load_addr = a; bus.load_data = d;
        @(posedge clk); #1;
        bus.load_en = 1'b0;
    endtask

    task automatic start_run(input logic [5:0] len);
        bus.prog_len = len; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL done_timeout: got no done within 100 cycles, expected a done pulse");
        end
        @(posedge clk); #1;
    endtask

    task automatic check_zero(input string name);
        vectors++;
        if ({bus.instruction, bus.issue_valid, bus.busy, bus.done, bus.pc} !== 29'h0) begin
            miscompares++;
            $display("FAIL %s: got instr=%h valid=%0b busy=%0b done=%0b pc=%0d, expected all zero",
                     name, bus.instruction, bus.issue_valid, bus.busy, bus.done, bus.pc);
        end
    endtask

    initial begin
        bus.load_en = 1'b0; bus.load_addr = '0; bus.load_data = '0;
        bus.prog_len = '0; bus.start = 1'b0; bus.stop = 1'b0;
        rst = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 check_zero("reset_state");
        rst = 1'b0;
        @(posedge clk); #1;

`ifdef INSTR_ISSUER_LOOP_EN
        load(5'd0, 20'h0_0001);
        load(5'd1, 20'h0_0002);
        for (int k = 0; k < 3; k++) begin
            exp_word(20'h0_0001, 5'd0, 1);
            exp_word(20'h0_0002, 5'd1, 1);
        end
        exp_done();
        start_run(6'd2);
        repeat (5) @(posedge clk);
        #1 bus.stop = 1'b1;
        @(posedge clk); #1 bus.stop = 1'b0;
        wait_done();
`else
        // Single std_op word: 3 cycles then done.
        load(5'd0, 20'h4_1230);
        exp_word(20'h4_1230, 5'd0, 3); exp_done();
        start_run(6'd1);
        wait_done();

        // Two mem words back to back; start/load mid-run are ignored.
        load(5'd0, 20'h8_0050);
        load(5'd1, 20'hC_0050);
        exp_word(20'h8_0050, 5'd0, 4); exp_word(20'hC_0050, 5'd1, 4); exp_done();
        start_run(6'd2);
        bus.start = 1'b1; bus.load_en = 1'b1; bus.load_addr = 5'd1; bus.load_data = 20'hF_FFFF;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.load_en = 1'b0;
        wait_done();
        exp_word(20'h8_0050, 5'd0, 4); exp_word(20'hC_0050, 5'd1, 4); exp_done();
        start_run(6'd2);
        wait_done();

        // Stop in cycle 2 of word 0.
        load(5'd0, 20'h4_0001);
        load(5'd1, 20'h4_0002);
        load(5'd2, 20'h4_0003);
        exp_word(20'h4_0001, 5'd0, 3); exp_done();
        start_run(6'd3);
        @(posedge clk); #1 bus.stop = 1'b1;
        @(posedge clk); #1 bus.stop = 1'b0;
        wait_done();

        // Empty program.
        exp_done();
        start_run(6'd0);
        wait_done();

        // Class mix: 1, 3 and 4 cycle holds.
        load(5'd0, 20'h0_0011);
        load(5'd1, 20'h4_0022);
        load(5'd2, 20'h8_0033);
        exp_word(20'h0_0011, 5'd0, 1); exp_word(20'h4_0022, 5'd1, 3);
        exp_word(20'h8_0033, 5'd2, 4); exp_done();
        start_run(6'd3);
        wait_done();

        // Stop coinciding with the last word's completion: one done only.
        exp_word(20'h0_0011, 5'd0, 1); exp_done();
        start_run(6'd1);
        bus.stop = 1'b1;
        wait_done();
        bus.stop = 1'b0;
        repeat (2) @(posedge clk); #1;

        // Reset mid-hold of word 1, then rerun from the untouched store.
        load(5'd0, 20'h8_0050);
        load(5'd1, 20'hC_0050);
        exp_word(20'h8_0050, 5'd0, 4); exp_word(20'hC_0050, 5'd1, 2);
        start_run(6'd2);
        repeat (6) @(posedge clk);
        #3 rst = 1'b1;
        #1 check_zero("reset_mid_issue");
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        exp_word(20'h8_0050, 5'd0, 4); exp_word(20'hC_0050, 5'd1, 4); exp_done();
        start_run(6'd2);
        wait_done();
`endif

        repeat (3) @(posedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL leftover_expected: got %0d unconsumed entries, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/instr_issuer.md
INSTR_ISSUER -- requirements
Module: instr_issuer

Interface
REQ-001 Parameter INSTR_WIDTH, default 20, SHALL set the width of the instruction word.
REQ-002 Parameter PROG_ADDR_BITS, default 5, SHALL set the program store depth to 2**PROG_ADDR_BITS words (32 by default).
REQ-003 Parameter STD_CYCLES, default 3, SHALL set the hold cycles for class 2'b01 (std_op).
REQ-004 Parameter MEM_CYCLES, default 4, SHALL set the hold cycles for classes 2'b10 (loadR) and 2'b11 (storeR).
REQ-005 Port clk, input, 1: the single clock; all state SHALL update on the rising edge.
REQ-006 Port rst, input, 1: reset, asynchronous and active-high.
REQ-007 Port load_en, input, 1: write strobe for the program store.
REQ-008 Port load_addr, input, PROG_ADDR_BITS: program store write address.
REQ-009 Port load_data, input, INSTR_WIDTH: program store write data.
REQ-010 Port prog_len, input, PROG_ADDR_BITS+1: number of instructions to issue (0..32); sampled on start.
REQ-011 Port start, input, 1: begin issuing from address 0.
REQ-012 Port stop, input, 1: request an end of issue once the current instruction completes.
REQ-013 Port instruction, output, INSTR_WIDTH: instruction word driven to the CU instruction input.
REQ-014 Port issue_valid, output, 1: high while instruction holds a program word.
REQ-015 Port busy, output, 1: high in the ISSUE state.
REQ-016 Port done, output, 1: one-cycle pulse at the end of a run.
REQ-017 Port pc, output, PROG_ADDR_BITS: address of the word currently issued.

Function
REQ-018 The state machine SHALL have three states: IDLE, ISSUE and DONE; any unencoded state SHALL return to IDLE on the next clock.
REQ-019 In IDLE, load_en=1 SHALL write load_data to the store at load_addr; load_en SHALL be ignored in ISSUE and DONE.
REQ-020 In IDLE, start=1 with a sampled prog_len>0 SHALL move to ISSUE with pc=0 on the next clock; the following values SHALL be registered at that same edge:
- instruction=store[0];
- issue_valid=1;
- hold counter loaded.
REQ-021 In IDLE, start=1 with prog_len=0 SHALL move to DONE without issuing.
REQ-022 The hold counter SHALL be loaded from instruction bits [19:18] of the word being issued:
- 2'b01 loads STD_CYCLES;
- 2'b10 and 2'b11 load MEM_CYCLES;
- 2'b00 loads 1.
REQ-023 In ISSUE, the instruction word SHALL be held stable for exactly the loaded count of cycles; after that, the next word store[pc+1] SHALL be presented on the very next cycle, with no gap.
REQ-024 When the last word (pc=prog_len-1) completes its hold, the block SHALL move to DONE, drive instruction=0 and drive issue_valid=0.
REQ-025 stop=1 sampled at any cycle of ISSUE SHALL be latched; the current word SHALL complete its full hold, and then the block SHALL move to DONE without issuing further words.
REQ-026 start asserted in ISSUE or DONE SHALL be ignored.
REQ-027 DONE SHALL last one cycle with done=1 and SHALL then return to IDLE.
REQ-028 Outside ISSUE, instruction SHALL be 0 (class 2'b00, which holds the CU in its RESET state) and issue_valid SHALL be 0.
REQ-029 pc SHALL be modulo 2**PROG_ADDR_BITS, and the pc+1 computation SHALL wrap without overflow side effects.
REQ-030 If stop and the last-word completion occur in the same cycle, the block SHALL enter DONE once, with a single done pulse.

Reset
REQ-031 While rst=1, the block SHALL immediately be in state IDLE with every output at its reset value:
- instruction=0, issue_valid=0, busy=0, done=0, pc=0;
- hold counter=0 and stop latch=0.
REQ-032 Program store contents SHALL NOT be cleared by rst.
REQ-033 An rst asserted mid-ISSUE SHALL abort the run without a done pulse.

Configuration
REQ-034 With macro INSTR_ISSUER_LOOP_EN defined, completing word prog_len-1 SHALL wrap pc to 0 and continue issuing until stop is latched; only stop SHALL end the run.
REQ-035 Without INSTR_ISSUER_LOOP_EN, the run SHALL end after word prog_len-1 as in REQ-024.

Verification
REQ-036 Load store[0]=20'h4_1230, prog_len=1, start -> instruction=20'h41230 for exactly 3 cycles, then done=1 for 1 cycle, then IDLE.
REQ-037 Load store[0]=20'h8_0050, store[1]=20'hC_0050, prog_len=2 -> word 0 held 4 cycles, word 1 held 4 cycles back-to-back, pc 0 then 1, a single done pulse.
REQ-038 Run prog_len=3 with stop pulsed in cycle 2 of word 0 -> word 0 completes its hold, word 1 is never issued, done pulses.
REQ-039 prog_len=0 with start -> no issue_valid, done=1 on the next cycle.
REQ-040 rst asserted mid-hold of word 1 -> outputs are 0 immediately with no done pulse; the store is intact and a rerun issues the same words.
REQ-041 With INSTR_ISSUER_LOOP_EN and prog_len=2 -> the sequence pc 0,1,0,1 continues until stop, then done pulses.
